rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port (wr/wr_dst/wr_data/high/low) between the WB stage and
//  an auxiliary long-latency requester (multi-cycle mul/div, interrupt context restore).
//  WB has fixed priority. Aux writes queue in a FIFO and drain on idle port cycles.
//  Exports a per-register pending mask for ID stall decisions, and a starvation stall request to the pipeline.
// PARAMETERS
//  DEPTH       4   aux FIFO entries; power of two, >=2
//  STARVE_MAX  8   consecutive blocked cycles with a non-empty FIFO before stall_req asserts; >=1
// PORTS
//  clk          in   1   clock; sole clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  wb_wr        in   1   WB write request; always accepted, no backpressure
//  wb_dst       in   4   WB destination register
//  wb_data      in   32  WB write data
//  wb_high      in   1   WB upper-half write enable, passed through
//  wb_low       in   1   WB lower-half write enable, passed through
//  aux_valid    in   1   aux request valid
//  aux_ready    out  1   aux accept; = !full
//  aux_dst      in   4   aux destination register
//  aux_data     in   32  aux write data
//  aux_high     in   1   aux upper-half enable
//  aux_low      in   1   aux lower-half enable
//  wr           out  1   to register file: write strobe (registered)
//  wr_dst       out  4   to register file: destination (registered)
//  wr_data      out  32  to register file: data (registered)
//  high         out  1   to register file: upper-half enable (registered)
//  low          out  1   to register file: lower-half enable (registered)
//  pend_mask    out  16  bit r set while any FIFO entry targets r
//  stall_req    out  1   to hazard/IF logic: freeze issue so WB goes idle
// BEHAVIOUR
//  - Reset: FIFO empty, pointers=0, starve_cnt=0, FSM=IDLE. wr/high/low/stall_req=0, wr_dst=0, wr_data=0,
//    pend_mask=0, aux_ready=1.
//  - Aux handshake: an entry is accepted when aux_valid&&aux_ready. Payload must hold while valid&&!ready.
//  - Port select per cycle: wb_wr=1 -> WB wins; else FIFO non-empty -> pop head; else no write.
//    The winner is registered onto wr*/high/low next cycle. Latency is 1 cycle for both sources.
//  - Empty FIFO: aux is NOT bypassed; enqueue then earliest pop next cycle (aux latency >=2).
//  - Full FIFO: aux_ready=0. Push and pop in the same cycle when full is impossible, since ready is computed
//    before the pop.
//  - Non-full with simultaneous push and pop: count unchanged, both pointers advance, pointers wrap mod DEPTH.
//  - pend_mask: OR of one-hot(dst) over valid entries, recomputed from FIFO state. A bit clears in the cycle
//    after its last entry pops. It excludes the entry currently on wr*. ID bypass covers that entry.
//  - Same-cycle WB and FIFO pop with equal dst: WB writes; the FIFO entry writes later. Ordering is the
//    issuer's job via pend_mask; no check here.
//  - FSM states:
//      IDLE   FIFO empty.
//      PEND   non-empty; starve_cnt++ on each cycle wb_wr blocks a pop, reset to 0 on each pop.
//      STARVE stall_req=1 (registered); entered when starve_cnt reaches STARVE_MAX-1 and a pop is blocked.
//  - Transitions: IDLE->PEND on push; PEND->IDLE on the pop that empties; PEND->STARVE as above;
//    STARVE->PEND on first pop if still non-empty, else ->IDLE. starve_cnt=0 on every exit from PEND.
//  - stall_req deasserts the cycle after that pop.
//  - starve_cnt saturates at STARVE_MAX-1; width clog2(STARVE_MAX)+1.
//  - Reset mid-operation: queued entries discarded; an in-flight registered write is dropped (wr=0 next cycle).
// CONFIGURATION
//  RF_ARB_STATS_EN defined: adds outputs stat_aux_wr[15:0] (aux pops) and stat_starve[15:0] (STARVE entries).
//    Both are free-running, wrap at 2^16 and are cleared by rst.
//  RF_ARB_STATS_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 rst then idle 4 cycles -> wr=0, pend_mask=0, aux_ready=1, stall_req=0 throughout.
//  2 wb_wr=1 dst=3 data=0xDEADBEEF high=low=1, one cycle -> next cycle wr=1 wr_dst=3 wr_data=0xDEADBEEF
//    high=low=1; following cycle wr=0.
//  3 aux push dst=5 data=0x12345678 with WB idle -> pend_mask=0x0020 next cycle; write appears on wr* with
//    dst 5 on the cycle after; pend_mask=0 once it is on wr*.
//  4 push 4 aux entries (dst 1,2,3,4) while wb_wr=1 continuously -> aux_ready=0 after 4th;
//    stall_req=1 after STARVE_MAX blocked cycles; drop wb_wr -> entries write in order 1,2,3,4;
//    stall_req=0 after first pop.
//  5 full FIFO with wb_wr=0 and aux_valid=1 held -> one pop per cycle; aux_ready=1 the cycle after first pop;
//    new entry accepted; pointer wrap exercised over >=2*DEPTH pushes with data intact.
//  6 assert rst with 3 queued entries and stall_req=1 -> next cycle all outputs at reset values;
//    no queued write ever appears.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arbiter
//  Description : Register-file write-port arbiter. WB has fixed priority; aux
//                writes queue in a FIFO and drain on idle port cycles.
//                Optional statistics counters enabled by RF_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wr,
    input  logic [3:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic        wb_high,
    input  logic        wb_low,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [3:0]  aux_dst,
    input  logic [31:0] aux_data,
    input  logic        aux_high,
    input  logic        aux_low,
    output logic        wr,
    output logic [3:0]  wr_dst,
    output logic [31:0] wr_data,
    output logic        high,
    output logic        low,
    output logic [15:0] pend_mask,
`ifdef RF_ARB_STATS_EN
    output logic [15:0] stat_aux_wr,
    output logic [15:0] stat_starve,
`endif
    output logic        stall_req
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(STARVE_MAX) + 1;
    localparam logic [ADDR_W:0]  C_FULL      = DEPTH[ADDR_W:0];
    localparam logic [CNT_W-1:0] C_STARVE_LIM = CNT_W'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_STARVE = 2'd2
    } state_t;

    logic [3:0]        r_mem_dst  [DEPTH];
    logic [31:0]       r_mem_data [DEPTH];
    logic [DEPTH-1:0]  r_mem_high;
    logic [DEPTH-1:0]  r_mem_low;
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [CNT_W-1:0]  r_starve_cnt;
    state_t            r_state;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W:0]   w_count_nxt;

    // Ready is derived from registered occupancy, so a full FIFO never pushes and pops together.
    assign aux_ready   = (r_count != C_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = aux_valid && aux_ready;
    assign w_pop       = !wb_wr && !w_empty;
    assign w_count_nxt = r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dst[r_wptr]  <= aux_dst;
            r_mem_data[r_wptr] <= aux_data;
            r_mem_high[r_wptr] <= aux_high;
            r_mem_low[r_wptr]  <= aux_low;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) pend_mask[r_mem_dst[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr      <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
            high    <= 1'b0;
            low     <= 1'b0;
        end else if (wb_wr) begin
            wr      <= 1'b1;
            wr_dst  <= wb_dst;
            wr_data <= wb_data;
            high    <= wb_high;
            low     <= wb_low;
        end else if (w_pop) begin
            wr      <= 1'b1;
            wr_dst  <= r_mem_dst[r_rptr];
            wr_data <= r_mem_data[r_rptr];
            high    <= r_mem_high[r_rptr];
            low     <= r_mem_low[r_rptr];
        end else begin
            wr      <= 1'b0;
            high    <= 1'b0;
            low     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            stall_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) r_state <= ST_PEND;
                end
                ST_PEND: begin
                    if (w_pop) begin
                        r_starve_cnt <= '0;
                        if (w_count_nxt == '0) r_state <= ST_IDLE;
                    end else if (wb_wr) begin
                        if (r_starve_cnt == C_STARVE_LIM) begin
                            r_state      <= ST_STARVE;
                            r_starve_cnt <= '0;
                            stall_req    <= 1'b1;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                ST_STARVE: begin
                    if (w_pop) begin
                        stall_req <= 1'b0;
                        r_state   <= (w_count_nxt == '0) ? ST_IDLE : ST_PEND;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_starve_cnt <= '0;
                    stall_req    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_aux_wr <= '0;
            stat_starve <= '0;
        end else begin
            if (w_pop) stat_aux_wr <= stat_aux_wr + 1'b1;
            if (r_state == ST_PEND && !w_pop && wb_wr && r_starve_cnt == C_STARVE_LIM)
                stat_starve <= stat_starve + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wport_arbiter
//  Description : Directed self-checking bench for rf_wport_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wr;
    logic [3:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_high;
    logic        wb_low;
    logic        aux_valid;
    logic        aux_ready;
    logic [3:0]  aux_dst;
    logic [31:0] aux_data;
    logic        aux_high;
    logic        aux_low;
    logic        wr;
    logic [3:0]  wr_dst;
    logic [31:0] wr_data;
    logic        high;
    logic        low;
    logic [15:0] pend_mask;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data), .wb_high(wb_high), .wb_low(wb_low),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dst(aux_dst), .aux_data(aux_data),
        .aux_high(aux_high), .aux_low(aux_low),
        .wr(wr), .wr_dst(wr_dst), .wr_data(wr_data), .high(high), .low(low),
        .pend_mask(pend_mask), .stall_req(stall_req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_wr = 0; wb_dst = 0; wb_data = 0; wb_high = 0; wb_low = 0;
        aux_valid = 0; aux_dst = 0; aux_data = 0; aux_high = 0; aux_low = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wr !== 1'b0 || pend_mask !== 16'h0 || aux_ready !== 1'b1 || stall_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: wr=%b pend=%h rdy=%b stall=%b, want 0 0000 1 0",
                         i, wr, pend_mask, aux_ready, stall_req);
            end
        end
    endtask

    task automatic test_wb_write();
        wb_wr = 1; wb_dst = 4'd3; wb_data = 32'hDEADBEEF; wb_high = 1; wb_low = 1;
        tick();
        idle_inputs();
        checks++;
        if (wr !== 1'b1 || wr_dst !== 4'd3 || wr_data !== 32'hDEADBEEF || high !== 1'b1 || low !== 1'b1) begin
            errors++;
            $display("FAIL wb_write: wr=%b dst=%0d data=%h h=%b l=%b, want 1 3 deadbeef 1 1",
                     wr, wr_dst, wr_data, high, low);
        end
        tick();
        checks++;
        if (wr !== 1'b0) begin
            errors++;
            $display("FAIL wb_write_end: wr=%b, want 0", wr);
        end
    endtask

    task automatic test_aux_single();
        aux_valid = 1; aux_dst = 4'd5; aux_data = 32'h12345678; aux_high = 1; aux_low = 0;
        tick();
        idle_inputs();
        checks++;
        if (pend_mask !== 16'h0020 || wr !== 1'b0) begin
            errors++;
            $display("FAIL aux_pend: pend=%h wr=%b, want 0020 0", pend_mask, wr);
        end
        tick();
        checks++;
        if (wr !== 1'b1 || wr_dst !== 4'd5 || wr_data !== 32'h12345678 || high !== 1'b1 || low !== 1'b0
            || pend_mask !== 16'h0) begin
            errors++;
            $display("FAIL aux_write: wr=%b dst=%0d data=%h h=%b l=%b pend=%h, want 1 5 12345678 1 0 0000",
                     wr, wr_dst, wr_data, high, low, pend_mask);
        end
        tick();
    endtask

    task automatic test_starve();
        wb_wr = 1; wb_dst = 4'hF; wb_data = 32'hCAFE0000;
        for (int i = 1; i <= 4; i++) begin
            aux_valid = 1; aux_dst = 4'(i); aux_data = 32'hA0 + 32'(i);
            tick();
        end
        aux_valid = 0;
        checks++;
        if (aux_ready !== 1'b0 || pend_mask !== 16'h001E) begin
            errors++;
            $display("FAIL starve_full: rdy=%b pend=%h, want 0 001e", aux_ready, pend_mask);
        end
        // First push landed 4 edges ago; 8 blocked cycles elapse 5 edges from now.
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL starve_early: stall_req=%b, want 0", stall_req);
        end
        tick();
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL starve_assert: stall_req=%b, want 1", stall_req);
        end
        wb_wr = 0;
        tick();
        checks++;
        if (stall_req !== 1'b0 || wr !== 1'b1 || wr_dst !== 4'd1 || wr_data !== 32'hA1
            || pend_mask !== 16'h001C || aux_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_first_pop: stall=%b wr=%b dst=%0d data=%h pend=%h rdy=%b, want 0 1 1 a1 001c 1",
                     stall_req, wr, wr_dst, wr_data, pend_mask, aux_ready);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++;
            if (wr !== 1'b1 || wr_dst !== 4'(i) || wr_data !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL starve_order%0d: wr=%b dst=%0d data=%h, want 1 %0d %h",
                         i, wr, wr_dst, wr_data, i, 32'hA0 + 32'(i));
            end
        end
        checks++;
        if (pend_mask !== 16'h0) begin
            errors++;
            $display("FAIL starve_drain_pend: pend=%h, want 0000", pend_mask);
        end
        tick();
        checks++;
        if (wr !== 1'b0) begin
            errors++;
            $display("FAIL starve_drained: wr=%b, want 0", wr);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int popped;
        bit acc;
        pushed = 0; popped = 0;
        wb_wr = 1; wb_dst = 4'hE; wb_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            aux_valid = 1; aux_dst = 4'(i); aux_data = 32'hB5000000 + 32'(i);
            tick();
            pushed++;
        end
        checks++;
        if (aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full: rdy=%b, want 0", aux_ready);
        end
        wb_wr = 0;
        for (int cyc = 0; cyc < 60 && popped < 12; cyc++) begin
            aux_valid = (pushed < 12);
            aux_dst   = 4'(pushed);
            aux_data  = 32'hB5000000 + 32'(pushed);
            acc       = aux_valid && aux_ready;
            tick();
            if (acc) pushed++;
            if (cyc == 0) begin
                checks++;
                if (aux_ready !== 1'b1 || acc) begin
                    errors++;
                    $display("FAIL wrap_ready_after_pop: rdy=%b acc_while_full=%b, want 1 0", aux_ready, acc);
                end
            end
            if (wr === 1'b1) begin
                checks++;
                if (wr_dst !== 4'(popped) || wr_data !== 32'hB5000000 + 32'(popped)) begin
                    errors++;
                    $display("FAIL wrap_data%0d: dst=%0d data=%h, want %0d %h",
                             popped, wr_dst, wr_data, popped, 32'hB5000000 + 32'(popped));
                end
                popped++;
            end
        end
        aux_valid = 0;
        checks++;
        if (popped != 12 || pushed != 12) begin
            errors++;
            $display("FAIL wrap_total: popped=%0d pushed=%0d, want 12 12", popped, pushed);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        wb_wr = 1; wb_dst = 4'h7; wb_data = 32'h77777777; wb_high = 1; wb_low = 1;
        for (int i = 0; i < 3; i++) begin
            aux_valid = 1; aux_dst = 4'(8 + i); aux_data = 32'hD0 + 32'(i);
            tick();
        end
        aux_valid = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (stall_req === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_stall: stall_req never asserted within 20 cycles");
        end
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        checks++;
        if (wr !== 1'b0 || wr_dst !== 4'd0 || wr_data !== 32'h0 || high !== 1'b0 || low !== 1'b0
            || pend_mask !== 16'h0 || aux_ready !== 1'b1 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: wr=%b dst=%0d data=%h h=%b l=%b pend=%h rdy=%b stall=%b, want reset values",
                     wr, wr_dst, wr_data, high, low, pend_mask, aux_ready, stall_req);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (wr !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_write cyc%0d: wr=%b dst=%0d, want wr 0", i, wr, wr_dst);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_wb_write();
        test_aux_single();
        test_starve();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
